// File: rtl/uart_rx_pkt_buf_if.sv
// Byte-stream handshake bundle shared by the UART-side input and the
// downstream output of the packet buffer.
interface uart_rx_pkt_buf_if;
   logic       tvalid;
   logic       tready;
   logic [7:0] tdata;
   logic       tlast;
   logic       terr;

   modport master (output tvalid, tdata, tlast, terr, input tready);
   modport slave  (input tvalid, tdata, tlast, terr, output tready);
endinterface

// File: rtl/uart_rx_pkt_buf.sv
// Packet store-and-forward buffer behind the UART receiver. Bytes are written
// speculatively and only become visible to the reader once the packet's last
// byte commits; overflowed or errored packets are rewound and counted.
module uart_rx_pkt_buf #(
   parameter  int unsigned DEPTH  = 64,
   parameter  int unsigned DROP_W = 16,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   uart_rx_pkt_buf_if.slave  s,
   uart_rx_pkt_buf_if.master m,
   output logic [AW:0]       pkt_cnt,
   output logic [AW:0]       level,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              overflow
);

   typedef enum logic {RECV, DISCARD} state_t;

   localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

   logic [8:0]        mem [DEPTH];
   state_t            state_q, state_d;
   logic [AW:0]       wr_q, wr_d;
   logic [AW:0]       cmt_q, cmt_d;
   logic [AW:0]       rd_q, rd_d;
   logic [AW:0]       pkt_q, pkt_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              ovf_q, ovf_d;
   logic              full, wr_en, drop, commit, rd_fire, rd_last;

   // The receiver has no flow control, so every byte is always accepted.
   assign s.tready = 1'b1;

   // Read side: only committed bytes are exposed; data comes straight from memory.
   assign m.tvalid            = (rd_q != cmt_q);
   assign {m.tlast, m.tdata}  = mem[rd_q[AW-1:0]];
   assign m.terr              = 1'b0;

   assign pkt_cnt  = pkt_q;
   assign level    = wr_q - rd_q;
   assign drop_cnt = drop_q;
   assign overflow = ovf_q;

   // Next-state decode for the write FSM, pointers and counters.
   always_comb begin
      full    = ((wr_q - rd_q) == DEPTH_P);
      rd_fire = m.tvalid && m.tready;
      rd_last = rd_fire && m.tlast;
      wr_en   = 1'b0;
      drop    = 1'b0;
      commit  = 1'b0;
      state_d = state_q;

      if (s.tvalid) begin
         case (state_q)
            RECV: begin
               if (full || s.terr) begin
                  if (s.tlast) drop = 1'b1;
                  else         state_d = DISCARD;
               end else begin
                  wr_en  = 1'b1;
                  commit = s.tlast;
               end
            end
            DISCARD: begin
               if (s.tlast) begin
                  drop    = 1'b1;
                  state_d = RECV;
               end
            end
            default: state_d = RECV;
         endcase
      end

      // A drop rewinds the speculative pointer to the last committed boundary.
      wr_d  = drop ? cmt_q : (wr_en ? wr_q + 1'b1 : wr_q);
      cmt_d = commit ? wr_q + 1'b1 : cmt_q;
      rd_d  = rd_fire ? rd_q + 1'b1 : rd_q;

      // Commit and last-byte read in the same cycle cancel out.
      case ({commit, rd_last})
         2'b10:   pkt_d = pkt_q + 1'b1;
         2'b01:   pkt_d = pkt_q - 1'b1;
         default: pkt_d = pkt_q;
      endcase

      drop_d = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
      ovf_d  = drop;
   end

   // State, pointer and counter registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RECV;
         wr_q    <= '0;
         cmt_q   <= '0;
         rd_q    <= '0;
         pkt_q   <= '0;
         drop_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         cmt_q   <= cmt_d;
         rd_q    <= rd_d;
         pkt_q   <= pkt_d;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   end

   // Packet storage {last, data}; contents are irrelevant after reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_q[AW-1:0]] <= {s.tlast, s.tdata};
   end

endmodule

// File: tb/tb_uart_rx_pkt_buf.sv
// Directed and randomized bench for uart_rx_pkt_buf, checked every cycle
// against a queue-based packet model.
module tb_uart_rx_pkt_buf;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_rx_pkt_buf_if s_if ();
   uart_rx_pkt_buf_if m_if ();

   logic [AW:0] pkt_cnt, level;
   logic [15:0] drop_cnt;
   logic        overflow;

   uart_rx_pkt_buf #(.DEPTH(DEPTH), .DROP_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .s        (s_if),
      .m        (m_if),
      .pkt_cnt  (pkt_cnt),
      .level    (level),
      .drop_cnt (drop_cnt),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Model: committed bytes {last,data}, in-progress packet, discard mode.
   logic [8:0]  mq [$];
   logic [7:0]  cur [$];
   bit          discard_m;
   int unsigned drops_m;
   bit          ovf_m;
   bit          rnd_rdy;
   int unsigned ovf_seen, last_seen;
   int unsigned checks, failures;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned count_lasts();
      int unsigned n = 0;
      foreach (mq[i]) if (mq[i][8]) n++;
      return n;
   endfunction

   function automatic void model_drop();
      cur.delete();
      drops_m++;
      ovf_m = 1'b1;
   endfunction

   function automatic void model_reset();
      mq.delete();
      cur.delete();
      discard_m = 1'b0;
      drops_m   = 0;
      ovf_m     = 1'b0;
   endfunction

   // Check outputs against the model, advance one clock, update the model.
   task automatic cycle();
      bit full_m;
      if (rnd_rdy) m_if.tready = 1'($urandom_range(0, 1));
      chk("m_tvalid", {31'd0, m_if.tvalid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("m_tdata", {24'd0, m_if.tdata}, {24'd0, mq[0][7:0]});
         chk("m_tlast", {31'd0, m_if.tlast}, {31'd0, mq[0][8]});
      end
      chk("pkt_cnt", {27'd0, pkt_cnt}, count_lasts());
      chk("level", {27'd0, level}, mq.size() + cur.size());
      chk("drop_cnt", {16'd0, drop_cnt}, (drops_m > 65535) ? 65535 : drops_m);
      chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
      if (overflow === 1'b1) ovf_seen++;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1 && m_if.tlast === 1'b1) last_seen++;
      @(posedge clk);
      full_m = ((mq.size() + cur.size()) == DEPTH);
      ovf_m  = 1'b0;
      if (mq.size() != 0 && m_if.tready) void'(mq.pop_front());
      if (s_if.tvalid) begin
         if (discard_m) begin
            if (s_if.tlast) begin
               model_drop();
               discard_m = 1'b0;
            end
         end else if (full_m || s_if.terr) begin
            if (s_if.tlast) model_drop();
            else            discard_m = 1'b1;
         end else begin
            cur.push_back(s_if.tdata);
            if (s_if.tlast) begin
               foreach (cur[i]) mq.push_back({(i == cur.size() - 1), cur[i]});
               cur.delete();
            end
         end
      end
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit l, input bit e);
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.terr   = e;
      cycle();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.terr   = 1'b0;
   endtask

   task automatic drain(input int unsigned n);
      m_if.tready = 1'b1;
      repeat (n) cycle();
   endtask

   initial begin
      int unsigned l0, d0, o0, len;
      logic [7:0]  held;

      checks = 0; failures = 0; rnd_rdy = 1'b0;
      ovf_seen = 0; last_seen = 0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.terr = 1'b0;
      m_if.tready = 1'b0;
      model_reset();

      // Reset state
      @(posedge clk); #1;
      chk("rst_tvalid", {31'd0, m_if.tvalid}, 0);
      chk("rst_pkt", {27'd0, pkt_cnt}, 0);
      chk("rst_level", {27'd0, level}, 0);
      chk("rst_drop", {16'd0, drop_cnt}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Single packet: visible exactly one cycle after the tlast write
      m_if.tready = 1'b1;
      l0 = last_seen;
      send_byte(8'h11, 0, 0);
      send_byte(8'h22, 0, 0);
      chk("single_early", {31'd0, m_if.tvalid}, 0);
      send_byte(8'h33, 1, 0);
      chk("single_lat", {31'd0, m_if.tvalid}, 1);
      chk("single_pkt", {27'd0, pkt_cnt}, 1);
      drain(4);
      chk("single_lasts", last_seen - l0, 1);

      // Backpressure: three 4-byte packets held while stalled
      m_if.tready = 1'b0;
      l0 = last_seen;
      for (int p = 0; p < 3; p++)
         for (int b = 0; b < 4; b++) send_byte(8'(16 * p + b + 1), b == 3, 0);
      chk("bp_pkt", {27'd0, pkt_cnt}, 3);
      chk("bp_level", {27'd0, level}, 12);
      held = m_if.tdata;
      for (int i = 0; i < 50; i++) begin
         cycle();
         chk("bp_stable_v", {31'd0, m_if.tvalid}, 1);
         chk("bp_stable_d", {24'd0, m_if.tdata}, {24'd0, held});
      end
      drain(16);
      chk("bp_lasts", last_seen - l0, 3);

      // Overflow: 12-byte A fits, 6-byte B overruns the 16-entry store
      m_if.tready = 1'b0;
      o0 = ovf_seen; l0 = last_seen;
      for (int b = 0; b < 12; b++) send_byte(8'(8'hA0 + b), b == 11, 0);
      for (int b = 0; b < 6; b++)  send_byte(8'(8'hB0 + b), b == 5, 0);
      cycle();
      cycle();
      chk("ovf_pulses", ovf_seen - o0, 1);
      chk("ovf_drop", {16'd0, drop_cnt}, 1);
      chk("ovf_level", {27'd0, level}, 12);
      drain(16);
      chk("ovf_lasts", last_seen - l0, 1);

      // Error drop: error on byte 3 rewinds, next good packet stands alone
      m_if.tready = 1'b0;
      l0 = last_seen;
      for (int b = 0; b < 5; b++) send_byte(8'(8'hC0 + b), b == 4, b == 2);
      send_byte(8'hAA, 0, 0);
      send_byte(8'hBB, 1, 0);
      chk("err_drop", {16'd0, drop_cnt}, 2);
      chk("err_level", {27'd0, level}, 2);
      drain(4);
      chk("err_lasts", last_seen - l0, 1);

      // Random packets with random ready, wrapping the small store
      l0 = last_seen; d0 = drop_cnt;
      rnd_rdy = 1'b1;
      for (int p = 0; p < 200; p++) begin
         len = $urandom_range(1, 20);
         for (int b = 0; b < int'(len); b++) begin
            send_byte(8'($urandom), b == int'(len) - 1, $urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) cycle();
         end
         repeat ($urandom_range(0, 3)) cycle();
      end
      rnd_rdy = 1'b0;
      drain(2 * DEPTH + 4);
      chk("rand_acct", (last_seen - l0) + (int'(drop_cnt) - d0), 200);

      // Reset mid-packet while output is valid
      m_if.tready = 1'b0;
      send_byte(8'h51, 0, 0);
      send_byte(8'h52, 1, 0);
      cycle();
      send_byte(8'h61, 0, 0);
      s_if.tvalid = 1'b1; s_if.tdata = 8'h62;
      rst = 1'b0;
      #1;
      chk("mid_tvalid", {31'd0, m_if.tvalid}, 0);
      chk("mid_pkt", {27'd0, pkt_cnt}, 0);
      chk("mid_level", {27'd0, level}, 0);
      chk("mid_drop", {16'd0, drop_cnt}, 0);
      chk("mid_ovf", {31'd0, overflow}, 0);
      model_reset();
      @(posedge clk);
      s_if.tvalid = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      l0 = last_seen;
      m_if.tready = 1'b1;
      send_byte(8'h71, 0, 0);
      send_byte(8'h72, 0, 0);
      send_byte(8'h73, 1, 0);
      drain(5);
      chk("mid_fresh", last_seen - l0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
